// File: rtl/prg_counter_fg.sv
// Fetch-group program counter: BOOT/RUN/HALT control, trap/branch redirects, valid/ready to fetch.
// Optional redirect event counter enabled by defining PRG_COUNTER_REDIR_CNT_EN.
module prg_counter_fg #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSN_SIZE   = 4,
    parameter int FETCH_WIDTH = 1,
    localparam int ADDR_OFS   = $clog2(INSN_SIZE),
    localparam int GRP_BITS   = $clog2(FETCH_WIDTH),
    localparam int CNT_W      = GRP_BITS + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:ADDR_OFS] rst_addr,
    input  logic                         trap_valid,
    input  logic [ADDR_WIDTH-1:ADDR_OFS] trap_addr,
    input  logic                         redir_valid,
    input  logic [ADDR_WIDTH-1:ADDR_OFS] redir_addr,
    input  logic                         halt_req,
    input  logic                         resume_req,
    input  logic                         pc_ready,
    output logic                         pc_valid,
    output logic [ADDR_WIDTH-1:ADDR_OFS] pc_addr,
    output logic [CNT_W-1:0]             pc_count,
    output logic                         halted
`ifdef PRG_COUNTER_REDIR_CNT_EN
    ,
    output logic [31:0]                  redir_cnt
`endif
);

    localparam int AW = ADDR_WIDTH - ADDR_OFS;
    localparam logic [AW-1:0] GRP_MASK = ~AW'(FETCH_WIDTH - 1);
    localparam logic [AW-1:0] GRP_STEP = AW'(FETCH_WIDTH);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          boot_seen;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] pc_inc;
    logic [CNT_W-1:0] grp_ofs;
    logic          consume;
    logic          redirect;

    assign pc_valid = (state_q == RUN);
    assign halted   = (state_q == HALT);
    assign pc_addr  = pc_q;
    assign consume  = pc_valid && pc_ready;
    assign redirect = trap_valid || redir_valid;

    // Next group always starts on a FETCH_WIDTH boundary.
    assign pc_inc = (pc_q & GRP_MASK) + GRP_STEP;

    generate
        if (GRP_BITS == 0) begin : g_single
            assign grp_ofs = '0;
        end else begin : g_group
            assign grp_ofs = CNT_W'(pc_q[GRP_BITS-1:0]);
        end
    endgenerate

    assign pc_count = CNT_W'(FETCH_WIDTH) - grp_ofs;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    if (boot_seen) state_d = RUN;
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (resume_req) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (trap_valid) begin
            pc_d = trap_addr;
        end else if (redir_valid) begin
            pc_d = redir_addr;
        end else if (state_q == BOOT) begin
            pc_d = rst_addr;
        end else if (consume) begin
            pc_d = pc_inc;
        end
    end

    // BOOT spans the first full cycle after release so pc_valid appears on edge two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            boot_seen <= 1'b0;
            pc_q      <= rst_addr;
        end else begin
            state_q   <= state_d;
            boot_seen <= 1'b1;
            pc_q      <= pc_d;
        end
    end

`ifdef PRG_COUNTER_REDIR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_cnt <= '0;
        end else if (redirect && (redir_cnt != 32'hFFFF_FFFF)) begin
            redir_cnt <= redir_cnt + 32'd1;
        end
    end
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_prg_counter_fg.sv
// Directed bench for prg_counter_fg: FETCH_WIDTH=4 main instance, FETCH_WIDTH=2 wrap instance.
// Expected group state is queued at drive time and compared after each edge.
module tb_prg_counter_fg;

    localparam int AW = 30;

    typedef struct {
        string          tag;
        logic           valid;
        logic [AW-1:0]  addr;
        int             cnt;
        logic           hlt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:2]   rst_addr;
    logic          trap_valid;
    logic [31:2]   trap_addr;
    logic          redir_valid;
    logic [31:2]   redir_addr;
    logic          halt_req;
    logic          resume_req;
    logic          pc_ready;

    logic          v4, h4, v2, h2;
    logic [31:2]   a4, a2;
    logic [2:0]    c4;
    logic [1:0]    c2;
`ifdef PRG_COUNTER_REDIR_CNT_EN
    logic [31:0]   rc4, rc2;
`endif

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    longint rc_exp = 0;

    always #5 clk = ~clk;

    prg_counter_fg #(.ADDR_WIDTH(32), .INSN_SIZE(4), .FETCH_WIDTH(4)) u_fw4 (
        .clk(clk), .rst_n(rst_n), .rst_addr(rst_addr),
        .trap_valid(trap_valid), .trap_addr(trap_addr),
        .redir_valid(redir_valid), .redir_addr(redir_addr),
        .halt_req(halt_req), .resume_req(resume_req),
        .pc_ready(pc_ready), .pc_valid(v4), .pc_addr(a4),
        .pc_count(c4), .halted(h4)
`ifdef PRG_COUNTER_REDIR_CNT_EN
        , .redir_cnt(rc4)
`endif
    );

    prg_counter_fg #(.ADDR_WIDTH(32), .INSN_SIZE(4), .FETCH_WIDTH(2)) u_fw2 (
        .clk(clk), .rst_n(rst_n), .rst_addr(rst_addr),
        .trap_valid(trap_valid), .trap_addr(trap_addr),
        .redir_valid(redir_valid), .redir_addr(redir_addr),
        .halt_req(halt_req), .resume_req(resume_req),
        .pc_ready(pc_ready), .pc_valid(v2), .pc_addr(a2),
        .pc_count(c2), .halted(h2)
`ifdef PRG_COUNTER_REDIR_CNT_EN
        , .redir_cnt(rc2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_top(input exp_t e);
        check({e.tag, ".valid"}, 64'(v4), 64'(e.valid));
        check({e.tag, ".addr"}, 64'(a4), 64'(e.addr));
        check({e.tag, ".count"}, 64'(c4), 64'(e.cnt));
        check({e.tag, ".halted"}, 64'(h4), 64'(e.hlt));
`ifdef PRG_COUNTER_REDIR_CNT_EN
        check({e.tag, ".redir_cnt"}, 64'(rc4), 64'(rc_exp));
`endif
    endtask

    task automatic step(input string tag, input logic v, input logic [AW-1:0] a,
                        input int c, input logic h);
        exp_t e;
        e.tag = tag; e.valid = v; e.addr = a; e.cnt = c; e.hlt = h;
        sb.push_back(e);
        if (rst_n && (trap_valid || redir_valid) && rc_exp != 64'hFFFF_FFFF)
            rc_exp++;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare_top(e);
    endtask

    task automatic idle();
        trap_valid = 1'b0; redir_valid = 1'b0;
        halt_req = 1'b0; resume_req = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; rst_addr = 30'h100;
        trap_addr = '0; redir_addr = '0;
        idle();
        pc_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        e.tag = "reset"; e.valid = 0; e.addr = 30'h100; e.cnt = 4; e.hlt = 0;
        compare_top(e);
        check("reset.fw2_count", 64'(c2), 64'd2);

        @(negedge clk) rst_n = 1'b1;
        step("boot_edge1", 0, 30'h100, 4, 0);
        step("boot_edge2", 1, 30'h100, 4, 0);
        step("seq_104", 1, 30'h104, 4, 0);
        step("seq_108", 1, 30'h108, 4, 0);

        redir_valid = 1'b1; redir_addr = 30'h203;
        step("redir_203", 1, 30'h203, 1, 0);
        check("redir_203.fw2_count", 64'(c2), 64'd1);
        idle();
        step("after_203", 1, 30'h204, 4, 0);

        trap_valid = 1'b1; trap_addr = 30'h40;
        redir_valid = 1'b1; redir_addr = 30'h80;
        step("trap_wins", 1, 30'h40, 4, 0);
        idle();
        step("after_trap", 1, 30'h44, 4, 0);

        redir_valid = 1'b1; redir_addr = 30'h10;
        step("redir_10", 1, 30'h10, 4, 0);
        idle();
        pc_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            step("bp_hold", 1, 30'h10, 4, 0);
        pc_ready = 1'b1;
        step("bp_release", 1, 30'h14, 4, 0);

        redir_valid = 1'b1; redir_addr = 30'h20;
        step("redir_20", 1, 30'h20, 4, 0);
        idle();
        halt_req = 1'b1;
        step("halt_consume", 0, 30'h24, 4, 1);
        idle();
        redir_valid = 1'b1; redir_addr = 30'h300;
        step("halt_redir", 0, 30'h300, 4, 1);
        idle();
        step("halt_hold", 0, 30'h300, 4, 1);
        resume_req = 1'b1;
        step("resume", 1, 30'h300, 4, 0);
        idle();
        pc_ready = 1'b0;
        halt_req = 1'b1; resume_req = 1'b1;
        step("both_in_run", 0, 30'h300, 4, 1);
        step("both_in_halt", 1, 30'h300, 4, 0);
        idle();

        pc_ready = 1'b1;
        redir_valid = 1'b1; redir_addr = 30'h3FFF_FFFE;
        step("wrap_setup", 1, 30'h3FFF_FFFE, 2, 0);
        check("wrap_setup.fw2_addr", 64'(a2), 64'h3FFF_FFFE);
        check("wrap_setup.fw2_count", 64'(c2), 64'd2);
        idle();
        step("wrap", 1, 30'h0, 4, 0);
        check("wrap.fw2_addr", 64'(a2), 64'h0);
        check("wrap.fw2_valid", 64'(v2), 64'd1);

        @(negedge clk);
        rst_addr = 30'h55;
        rst_n = 1'b0;
        rc_exp = 0;
        #1;
        e.tag = "mid_reset"; e.valid = 0; e.addr = 30'h55; e.cnt = 3; e.hlt = 0;
        compare_top(e);
        check("mid_reset.fw2_count", 64'(c2), 64'd1);
        check("mid_reset.fw2_valid", 64'(v2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
